// File: rtl/led_run_param.sv
// led_run_param: parametrised one-hot running-light generator.
// A prescaler divides the enabled clock by step_div+1. On each tick the LED
// pattern advances according to mode (rotate left, rotate right, ping-pong, hold).
// All outputs come straight from flops.
module led_run_param #(
  parameter int LED_W = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
  output logic [LED_W-1:0] led_o,
  output logic             dir_o,
  output logic             step_o
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [LED_W-1:0] LED_RST = LED_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             tick;

  // True when exactly one bit of the pattern is set.
  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < LED_W; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  // Circular move toward the MSB.
  function automatic logic [LED_W-1:0] rot_left(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  // Circular move toward the LSB.
  function automatic logic [LED_W-1:0] rot_right(input logic [LED_W-1:0] v);
    return {v[0], v[LED_W-1:1]};
  endfunction

  // Non-circular moves used by ping-pong; end bits are handled by the caller.
  function automatic logic [LED_W-1:0] shift_left(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], 1'b0};
  endfunction

  function automatic logic [LED_W-1:0] shift_right(input logic [LED_W-1:0] v);
    return {1'b0, v[LED_W-1:1]};
  endfunction

  // Prescaler: the >= compare ticks immediately if step_div drops below cnt.
  always_comb begin
    tick  = en && (cnt_q >= step_div);
    cnt_d = cnt_q + DIV_W'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  // Next pattern and direction, evaluated only on a tick.
  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = tick;
    if (tick) begin
      if (!is_onehot(led_q)) begin
        // Corrupted pattern recovers to bit0 regardless of mode.
        led_d = LED_RST;
        dir_d = 1'b0;
      end else begin
        case (mode)
          MODE_ROTL: begin
            led_d = rot_left(led_q);
            dir_d = 1'b0;
          end
          MODE_ROTR: begin
            led_d = rot_right(led_q);
            dir_d = 1'b1;
          end
          MODE_BOUNCE: begin
            // Direction carries over from whatever mode ran before.
            if (!dir_q) begin
              if (led_q[LED_W-1]) begin
                led_d = shift_right(led_q);
                dir_d = 1'b1;
              end else begin
                led_d = shift_left(led_q);
              end
            end else begin
              if (led_q[0]) begin
                led_d = shift_left(led_q);
                dir_d = 1'b0;
              end else begin
                led_d = shift_right(led_q);
              end
            end
          end
          default: begin
            // Hold: pattern frozen, step_o still pulses.
            led_d = led_q;
            dir_d = dir_q;
          end
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      led_q  <= LED_RST;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign led_o  = led_q;
  assign dir_o  = dir_q;
  assign step_o = step_q;

endmodule

// File: tb/tb_led_run_param.sv
// Bench for led_run_param: three instances (LED_W = 8, 2, 16).
// Stimulus pushes expected {dir, led} per step into queues; monitors pop on step_o.
module tb_led_run_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // LED_W = 8 instance
  logic        rst8_n, en8;
  logic [1:0]  mode8;
  logic [23:0] div8;
  logic [7:0]  led8;
  logic        dir8, step8;

  // LED_W = 2 and 16 instances share their inputs
  logic        rstb_n, enb;
  logic [1:0]  modeb;
  logic [23:0] divb;
  logic [1:0]  led2;
  logic        dir2, step2;
  logic [15:0] led16;
  logic        dir16, step16;

  led_run_param #(.LED_W(8), .DIV_W(24)) dut8 (
    .clk(clk), .rst_n(rst8_n), .en(en8), .mode(mode8), .step_div(div8),
    .led_o(led8), .dir_o(dir8), .step_o(step8));

  led_run_param #(.LED_W(2), .DIV_W(24)) dut2 (
    .clk(clk), .rst_n(rstb_n), .en(enb), .mode(modeb), .step_div(divb),
    .led_o(led2), .dir_o(dir2), .step_o(step2));

  led_run_param #(.LED_W(16), .DIV_W(24)) dut16 (
    .clk(clk), .rst_n(rstb_n), .en(enb), .mode(modeb), .step_div(divb),
    .led_o(led16), .dir_o(dir16), .step_o(step16));

  // Expected entries: {dir, led[15:0]}
  logic [16:0] q8[$];
  logic [16:0] q2[$];
  logic [16:0] q16[$];
  logic [16:0] e8, e2, e16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: step_o pulsed with no expected step (got 1 expected 0)", name);
  endtask

  task automatic push8(input logic d, input logic [7:0] v);
    q8.push_back({d, 8'h00, v});
  endtask

  // Monitors: compare each presented step against the scoreboard.
  always @(negedge clk) begin
    if (step8 === 1'b1) begin
      if (q8.size() == 0) unexpected("w8 step");
      else begin
        e8 = q8.pop_front();
        chk("w8 led", 32'(led8), 32'(e8[7:0]));
        chk("w8 dir", 32'(dir8), 32'(e8[16]));
      end
    end
  end

  always @(negedge clk) begin
    if (step2 === 1'b1) begin
      if (q2.size() == 0) unexpected("w2 step");
      else begin
        e2 = q2.pop_front();
        chk("w2 led", 32'(led2), 32'(e2[1:0]));
        chk("w2 dir", 32'(dir2), 32'(e2[16]));
      end
    end
  end

  always @(negedge clk) begin
    if (step16 === 1'b1) begin
      if (q16.size() == 0) unexpected("w16 step");
      else begin
        e16 = q16.pop_front();
        chk("w16 led", 32'(led16), 32'(e16[15:0]));
        chk("w16 dir", 32'(dir16), 32'(e16[16]));
      end
    end
  end

  task automatic seq8();
    logic [7:0] t2 [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] t3 [9]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [7:0] t4 [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic       d4 [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    // T1 reset and idle
    rst8_n = 1'b0; en8 = 1'b0; mode8 = 2'b00; div8 = 24'd0;
    repeat (3) @(negedge clk);
    chk("t1 reset led", 32'(led8), 32'h01);
    chk("t1 reset dir", 32'(dir8), 32'h0);
    chk("t1 reset step", 32'(step8), 32'h0);
    rst8_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1 idle led", 32'(led8), 32'h01);
    chk("t1 idle dir", 32'(dir8), 32'h0);
    // T2 rotate-left every 4 clocks
    div8 = 24'd3; mode8 = 2'b00;
    for (int k = 0; k < 8; k++) push8(1'b0, t2[k]);
    en8 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("t2 step timing", 32'(step8), (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    en8 = 1'b0;
    @(negedge clk);
    chk("t2 drained", 32'(q8.size()), 32'd0);
    // T3 rotate-right from reset, one step per clock
    #2 rst8_n = 1'b0;
    mode8 = 2'b01; div8 = 24'd0;
    @(negedge clk);
    rst8_n = 1'b1;
    for (int k = 0; k < 9; k++) push8(1'b1, t3[k]);
    en8 = 1'b1;
    repeat (9) begin
      @(negedge clk);
      chk("t3 step every clk", 32'(step8), 32'd1);
    end
    en8 = 1'b0;
    @(negedge clk);
    chk("t3 drained", 32'(q8.size()), 32'd0);
    // T4 ping-pong from reset
    #2 rst8_n = 1'b0;
    mode8 = 2'b10; div8 = 24'd0;
    @(negedge clk);
    rst8_n = 1'b1;
    for (int k = 0; k < 15; k++) push8(d4[k], t4[k]);
    en8 = 1'b1;
    repeat (15) @(negedge clk);
    en8 = 1'b0;
    @(negedge clk);
    chk("t4 drained", 32'(q8.size()), 32'd0);
    // T5 hold: step_o pulses, pattern frozen at 02
    mode8 = 2'b11; div8 = 24'd0;
    for (int k = 0; k < 4; k++) push8(1'b0, 8'h02);
    en8 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5 hold pulse", 32'(step8), 32'd1);
    end
    en8 = 1'b0;
    @(negedge clk);
    // T5 step_div lowered from 100 to 2 with cnt = 50
    mode8 = 2'b00; div8 = 24'd100; en8 = 1'b1;
    repeat (50) @(negedge clk);
    chk("t5 no early tick", 32'(step8), 32'd0);
    push8(1'b0, 8'h04);
    div8 = 24'd2;
    @(negedge clk);
    chk("t5 lowered div tick", 32'(step8), 32'd1);
    @(negedge clk);
    // T5 en drop mid-count clears the prescaler
    en8 = 1'b0;
    repeat (5) @(negedge clk);
    push8(1'b0, 8'h08);
    en8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5 restart timing", 32'(step8), (k == 2) ? 32'd1 : 32'd0);
    end
    en8 = 1'b0;
    @(negedge clk);
    // T6 illegal pattern recovers to 01, dir 0, even in rotate-right
    mode8 = 2'b01; div8 = 24'd0;
    #2 force dut8.led_q = 8'h03;
    #1 release dut8.led_q;
    push8(1'b0, 8'h01);
    en8 = 1'b1;
    @(negedge clk);
    chk("t6 recover pulse", 32'(step8), 32'd1);
    en8 = 1'b0;
    @(negedge clk);
    // T6 reset pulse mid-run
    mode8 = 2'b00; div8 = 24'd0;
    push8(1'b0, 8'h02);
    push8(1'b0, 8'h04);
    en8 = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1;
    chk("t6 async rst led", 32'(led8), 32'h01);
    chk("t6 async rst dir", 32'(dir8), 32'h0);
    chk("t6 async rst step", 32'(step8), 32'h0);
    div8 = 24'd3;
    @(negedge clk);
    rst8_n = 1'b1;
    push8(1'b0, 8'h02);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6 first tick after rst", 32'(step8), (k == 3) ? 32'd1 : 32'd0);
    end
    en8 = 1'b0;
    @(negedge clk);
    chk("w8 drained", 32'(q8.size()), 32'd0);
  endtask

  task automatic seqb();
    // Reset, then T2 rotate-left on LED_W = 2 and 16
    rstb_n = 1'b0; enb = 1'b0; modeb = 2'b00; divb = 24'd3;
    repeat (2) @(negedge clk);
    chk("wb reset led2", 32'(led2), 32'h1);
    chk("wb reset led16", 32'(led16), 32'h1);
    rstb_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      q2.push_back((k % 2 == 0) ? 17'h0_0002 : 17'h0_0001);
      q16.push_back((k < 15) ? {1'b0, 16'(16'h1 << (k + 1))} : 17'h0_0001);
    end
    enb = 1'b1;
    repeat (64) @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    chk("wb t2 drained w2", 32'(q2.size()), 32'd0);
    chk("wb t2 drained w16", 32'(q16.size()), 32'd0);
    // T4 ping-pong from reset
    #2 rstb_n = 1'b0;
    modeb = 2'b10; divb = 24'd0;
    @(negedge clk);
    rstb_n = 1'b1;
    for (int k = 1; k < 16; k++) q16.push_back({1'b0, 16'(16'h1 << k)});
    for (int k = 14; k >= 0; k--) q16.push_back({1'b1, 16'(16'h1 << k)});
    q16.push_back(17'h0_0002);
    for (int k = 0; k < 31; k++) q2.push_back((k % 2 == 0) ? 17'h0_0002 : 17'h1_0001);
    enb = 1'b1;
    repeat (31) @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    chk("wb t4 drained w2", 32'(q2.size()), 32'd0);
    chk("wb t4 drained w16", 32'(q16.size()), 32'd0);
  endtask

  initial begin
    fork
      seq8();
      seqb();
    join
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (got timeout expected finish)");
    $fatal(1, "watchdog expired");
  end

endmodule
